// File: rtl/dcache_ctrl_if.sv
// rtl/dcache_ctrl_if.sv - CPU, SRAM and memory signal bundle for the dcache controller
// Signal suffixes are from the controller's point of view.
interface dcache_ctrl_if;
   logic [31:0]  cpu_addr_i;
   logic [31:0]  cpu_data_i;
   logic         cpu_MemRead_i;
   logic         cpu_MemWrite_i;
   logic [31:0]  cpu_data_o;
   logic         cpu_stall_o;

   logic [3:0]   sram_addr_o;
   logic [24:0]  sram_tag_o;
   logic [255:0] sram_data_o;
   logic         sram_enable_o;
   logic         sram_write_o;
   logic [24:0]  sram_tag_i;
   logic [255:0] sram_data_i;
   logic         sram_hit_i;

   logic [31:0]  mem_addr_o;
   logic [255:0] mem_data_o;
   logic         mem_enable_o;
   logic         mem_write_o;
   logic [255:0] mem_data_i;
   logic         mem_ack_i;

   modport slave (
      input  cpu_addr_i, cpu_data_i, cpu_MemRead_i, cpu_MemWrite_i,
      output cpu_data_o, cpu_stall_o,
      output sram_addr_o, sram_tag_o, sram_data_o, sram_enable_o, sram_write_o,
      input  sram_tag_i, sram_data_i, sram_hit_i,
      output mem_addr_o, mem_data_o, mem_enable_o, mem_write_o,
      input  mem_data_i, mem_ack_i
   );

   modport master (
      output cpu_addr_i, cpu_data_i, cpu_MemRead_i, cpu_MemWrite_i,
      input  cpu_data_o, cpu_stall_o,
      input  sram_addr_o, sram_tag_o, sram_data_o, sram_enable_o, sram_write_o,
      output sram_tag_i, sram_data_i, sram_hit_i,
      input  mem_addr_o, mem_data_o, mem_enable_o, mem_write_o,
      output mem_data_i, mem_ack_i
   );
endinterface

// File: rtl/dcache_ctrl.sv
// rtl/dcache_ctrl.sv - write-back, write-allocate L1 dcache controller
// Lookup and write-hit merge are combinational; the miss path is a registered FSM.
module dcache_ctrl (
   input  logic         clk_i,
   input  logic         rst_i,
   dcache_ctrl_if.slave bus
);

   typedef enum logic [2:0] {
      IDLE,
      MISS,
      WRITEBACK,
      READMISS,
      READMISSOK
   } state_t;

   state_t        state_q, state_d;
   logic          mem_enable_q, mem_enable_d;
   logic          mem_write_q, mem_write_d;
   logic [31:0]   mem_addr_q, mem_addr_d;
   logic [255:0]  mem_data_q, mem_data_d;

   logic          req;
   logic          write_hit;
   logic          refill_we;
   logic [22:0]   cpu_tag;
   logic [3:0]    index;
   logic [2:0]    offset;
   logic [255:0]  merged_line;
   logic          addr_unused;

   assign req         = bus.cpu_MemRead_i | bus.cpu_MemWrite_i;
   assign cpu_tag     = bus.cpu_addr_i[31:9];
   assign index       = bus.cpu_addr_i[8:5];
   assign offset      = bus.cpu_addr_i[4:2];
   assign addr_unused = ^bus.cpu_addr_i[1:0];

   // Stores only commit from IDLE; during READMISSOK the re-lookup hits but the merge waits a cycle.
   assign write_hit = (state_q == IDLE) & bus.cpu_MemWrite_i & bus.sram_hit_i;
   assign refill_we = (state_q == READMISS) & bus.mem_ack_i;

   always_comb begin
      merged_line = bus.sram_data_i;
      merged_line[{offset, 5'b0} +: 32] = bus.cpu_data_i;
   end

   assign bus.sram_enable_o = req | refill_we;
   assign bus.sram_write_o  = write_hit | refill_we;
   assign bus.sram_addr_o   = index;
   assign bus.sram_tag_o    = {1'b1, write_hit, cpu_tag};
   assign bus.sram_data_o   = refill_we ? bus.mem_data_i : merged_line;

   assign bus.cpu_data_o  = bus.sram_data_i[{offset, 5'b0} +: 32];
   assign bus.cpu_stall_o = (state_q != IDLE) | (req & ~bus.sram_hit_i);

   assign bus.mem_enable_o = mem_enable_q;
   assign bus.mem_write_o  = mem_write_q;
   assign bus.mem_addr_o   = mem_addr_q;
   assign bus.mem_data_o   = mem_data_q;

   always_comb begin
      state_d      = state_q;
      mem_enable_d = mem_enable_q;
      mem_write_d  = mem_write_q;
      mem_addr_d   = mem_addr_q;
      mem_data_d   = mem_data_q;
      unique case (state_q)
         IDLE: begin
            if (req && !bus.sram_hit_i) state_d = MISS;
         end
         MISS: begin
            // The SRAM is presenting the LRU victim here since the lookup missed.
            mem_enable_d = 1'b1;
            if (bus.sram_tag_i[24] && bus.sram_tag_i[23]) begin
               mem_write_d = 1'b1;
               mem_addr_d  = {bus.sram_tag_i[22:0], index, 5'b0};
               mem_data_d  = bus.sram_data_i;
               state_d     = WRITEBACK;
            end else begin
               mem_write_d = 1'b0;
               mem_addr_d  = {cpu_tag, index, 5'b0};
               state_d     = READMISS;
            end
         end
         WRITEBACK: begin
            if (bus.mem_ack_i) begin
               mem_write_d = 1'b0;
               mem_addr_d  = {cpu_tag, index, 5'b0};
               state_d     = READMISS;
            end
         end
         READMISS: begin
            if (bus.mem_ack_i) begin
               mem_enable_d = 1'b0;
               state_d      = READMISSOK;
            end
         end
         READMISSOK: state_d = IDLE;
         default:    state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q      <= IDLE;
         mem_enable_q <= 1'b0;
         mem_write_q  <= 1'b0;
         mem_addr_q   <= 32'h0;
         mem_data_q   <= 256'h0;
      end else begin
         state_q      <= state_d;
         mem_enable_q <= mem_enable_d;
         mem_write_q  <= mem_write_d;
         mem_addr_q   <= mem_addr_d;
         mem_data_q   <= mem_data_d;
      end
   end

endmodule

// File: tb/tb_dcache_ctrl.sv
// tb/tb_dcache_ctrl.sv - directed bench with 2-way LRU SRAM model, latency memory model and txn scoreboard
module tb_dcache_ctrl;

   typedef struct {
      logic         w;
      logic [31:0]  a;
      logic [255:0] d;
   } mem_txn_t;

   logic clk;
   logic rst;
   dcache_ctrl_if bus();

   dcache_ctrl dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks;
   int errors;

   // SRAM model: 16 sets x 2 ways, per-set LRU bit naming the victim way.
   logic [24:0]  t_mem [16][2];
   logic [255:0] d_mem [16][2];
   logic         lru   [16];
   logic         sram_init;
   int           sram_wr_n;
   logic         hit_c;
   logic         sel_c;
   logic [3:0]   a_c;

   always_comb begin
      a_c   = bus.sram_addr_o;
      hit_c = 1'b0;
      sel_c = lru[a_c];
      for (int w = 0; w < 2; w++) begin
         if (t_mem[a_c][w][24] && t_mem[a_c][w][22:0] == bus.sram_tag_o[22:0]) begin
            hit_c = 1'b1;
            sel_c = w[0];
         end
      end
      bus.sram_hit_i  = hit_c;
      bus.sram_tag_i  = t_mem[a_c][sel_c];
      bus.sram_data_i = d_mem[a_c][sel_c];
   end

   always @(posedge clk) begin
      if (sram_init) begin
         for (int i = 0; i < 16; i++) begin
            for (int w = 0; w < 2; w++) begin
               t_mem[i][w] <= '0;
               d_mem[i][w] <= '0;
            end
            lru[i] <= 1'b0;
         end
      end else if (bus.sram_enable_o) begin
         if (bus.sram_write_o) begin
            t_mem[a_c][sel_c] <= bus.sram_tag_o;
            d_mem[a_c][sel_c] <= bus.sram_data_o;
            lru[a_c]          <= ~sel_c;
            sram_wr_n         <= sram_wr_n + 1;
         end else if (hit_c) begin
            lru[a_c] <= ~sel_c;
         end
      end
   end

   // Memory model: acks L cycles after a request becomes visible; each ack starts a fresh count.
   int           lat;
   int           cnt;
   logic         model_ack;
   logic         force_ack;
   logic [255:0] mem_rdata;
   logic         obs_w [32];
   logic [31:0]  obs_a [32];
   logic [255:0] obs_d [32];
   int           obs_n;

   function automatic logic [255:0] line_for(input logic [31:0] a);
      logic [255:0] l;
      for (int k = 0; k < 8; k++) l[k*32 +: 32] = 32'h5A00_0000 + a + k;
      if (a == 32'h40) l[31:0] = 32'hDEADBEEF;
      return l;
   endfunction

   assign bus.mem_ack_i  = model_ack | force_ack;
   assign bus.mem_data_i = mem_rdata;

   initial begin
      model_ack = 1'b0;
      cnt       = 0;
      obs_n     = 0;
      mem_rdata = '0;
   end

   always @(negedge clk) begin
      if (rst || !bus.mem_enable_o) begin
         cnt       = 0;
         model_ack = 1'b0;
      end else if (cnt >= lat) begin
         model_ack = 1'b1;
         cnt       = 0;
         mem_rdata = line_for(bus.mem_addr_o);
         if (obs_n < 32) begin
            obs_w[obs_n] = bus.mem_write_o;
            obs_a[obs_n] = bus.mem_addr_o;
            obs_d[obs_n] = bus.mem_data_o;
         end
         obs_n = obs_n + 1;
      end else begin
         model_ack = 1'b0;
         cnt       = cnt + 1;
      end
   end

   mem_txn_t exp_q[$];
   int       rd_ptr;

   task automatic chk(input string name, input logic [255:0] got, input logic [255:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   task automatic expect_txn(input logic w, input logic [31:0] a, input logic [255:0] d);
      mem_txn_t e;
      e.w = w;
      e.a = a;
      e.d = d;
      exp_q.push_back(e);
   endtask

   task automatic drain();
      mem_txn_t e;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         if (rd_ptr < obs_n) begin
            chk("txn_write", {255'h0, obs_w[rd_ptr]}, {255'h0, e.w});
            chk("txn_addr", {224'h0, obs_a[rd_ptr]}, {224'h0, e.a});
            if (e.w) chk("txn_wb_data", obs_d[rd_ptr], e.d);
            rd_ptr++;
         end else begin
            chk("txn_missing", obs_n, rd_ptr + 1);
         end
      end
      chk("txn_no_extra", obs_n, rd_ptr);
   endtask

   task automatic access(input logic [31:0] a, input logic [31:0] d, input logic r, input logic w,
                         output int stalls, output logic [31:0] rdata, output logic sw,
                         output logic [24:0] stag);
      @(negedge clk);
      bus.cpu_addr_i     = a;
      bus.cpu_data_i     = d;
      bus.cpu_MemRead_i  = r;
      bus.cpu_MemWrite_i = w;
      stalls = 0;
      #1;
      while (bus.cpu_stall_o && stalls < 200) begin
         stalls++;
         @(negedge clk);
         #1;
      end
      rdata = bus.cpu_data_o;
      sw    = bus.sram_write_o;
      stag  = bus.sram_tag_o;
      @(negedge clk);
      bus.cpu_MemRead_i  = 1'b0;
      bus.cpu_MemWrite_i = 1'b0;
   endtask

   initial begin
      int           st;
      logic [31:0]  rd;
      logic         sw;
      logic [24:0]  stg;
      logic [255:0] exp_line;
      int           fw;
      int           wn0;
      logic         seen_wb;

      checks = 0;
      errors = 0;
      rd_ptr = 0;
      lat = 10;
      force_ack = 1'b0;
      rst = 1'b1;
      sram_init = 1'b1;
      bus.cpu_addr_i = '0;
      bus.cpu_data_i = '0;
      bus.cpu_MemRead_i = 1'b0;
      bus.cpu_MemWrite_i = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      sram_init = 1'b0;
      #1;
      chk("rst_mem_enable", bus.mem_enable_o, 1'b0);
      chk("rst_mem_write", bus.mem_write_o, 1'b0);
      chk("rst_mem_addr", bus.mem_addr_o, 32'h0);
      chk("rst_mem_data", bus.mem_data_o, 256'h0);
      chk("rst_sram_enable", bus.sram_enable_o, 1'b0);
      chk("rst_sram_write", bus.sram_write_o, 1'b0);
      chk("rst_stall", bus.cpu_stall_o, 1'b0);

      // Cold load: one refill, stall 4+L.
      expect_txn(1'b0, 32'h40, '0);
      access(32'h40, 32'h0, 1'b1, 1'b0, st, rd, sw, stg);
      chk("cold_stall", st, 14);
      chk("cold_rdata", rd, 32'hDEADBEEF);
      chk("cold_no_sram_wr", sw, 1'b0);
      drain();

      access(32'h44, 32'h12345678, 1'b0, 1'b1, st, rd, sw, stg);
      chk("wr_hit_stall", st, 0);
      chk("wr_hit_we", sw, 1'b1);
      chk("wr_hit_tag_vd", stg[24:23], 2'b11);
      access(32'h44, 32'h0, 1'b1, 1'b0, st, rd, sw, stg);
      chk("rd_after_wr_stall", st, 0);
      chk("rd_after_wr_data", rd, 32'h12345678);
      drain();

      // Second way of set 2, then a conflict that evicts the dirty 0x40 line.
      expect_txn(1'b0, 32'h240, '0);
      access(32'h240, 32'h0, 1'b1, 1'b0, st, rd, sw, stg);
      chk("fill_240_stall", st, 14);
      exp_line = line_for(32'h40);
      exp_line[63:32] = 32'h12345678;
      expect_txn(1'b1, 32'h40, exp_line);
      expect_txn(1'b0, 32'h440, '0);
      access(32'h440, 32'h0, 1'b1, 1'b0, st, rd, sw, stg);
      chk("dirty_miss_stall", st, 25);
      chk("dirty_miss_rdata", rd, 32'h5A000440);
      drain();

      // Store miss allocates then merges.
      expect_txn(1'b0, 32'h80, '0);
      access(32'h80, 32'h0BADCAFE, 1'b0, 1'b1, st, rd, sw, stg);
      chk("st_miss_stall", st, 14);
      chk("st_miss_merge_we", sw, 1'b1);
      chk("st_miss_tag_vd", stg[24:23], 2'b11);
      drain();
      fw = -1;
      for (int w = 0; w < 2; w++)
         if (t_mem[4][w][24] && t_mem[4][w][22:0] == 23'h0) fw = w;
      chk("st_miss_line_present", fw >= 0, 1'b1);
      if (fw >= 0) begin
         exp_line = line_for(32'h80);
         exp_line[31:0] = 32'h0BADCAFE;
         chk("st_miss_line_tag", t_mem[4][fw], {2'b11, 23'h0});
         chk("st_miss_line_data", d_mem[4][fw], exp_line);
      end

      // Reset in WRITEBACK: fill set 4's other way, then miss on a third tag.
      expect_txn(1'b0, 32'h280, '0);
      access(32'h280, 32'h0, 1'b1, 1'b0, st, rd, sw, stg);
      chk("fill_280_stall", st, 14);
      drain();
      lat = 50;
      @(negedge clk);
      bus.cpu_addr_i = 32'h480;
      bus.cpu_MemRead_i = 1'b1;
      seen_wb = 1'b0;
      for (int i = 0; i < 20 && !seen_wb; i++) begin
         #1;
         if (bus.mem_enable_o && bus.mem_write_o) seen_wb = 1'b1;
         else @(negedge clk);
      end
      chk("rst_test_in_writeback", seen_wb, 1'b1);
      chk("rst_test_wb_addr", bus.mem_addr_o, 32'h80);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      bus.cpu_MemRead_i = 1'b0;
      #1;
      chk("rst_mid_mem_enable", bus.mem_enable_o, 1'b0);
      chk("rst_mid_idle", bus.cpu_stall_o, 1'b0);
      wn0 = sram_wr_n;
      force_ack = 1'b1;
      @(negedge clk);
      force_ack = 1'b0;
      #1;
      chk("stray_ack_no_sram_wr", sram_wr_n, wn0);
      chk("stray_ack_mem_enable", bus.mem_enable_o, 1'b0);
      chk("stray_ack_idle", bus.cpu_stall_o, 1'b0);
      lat = 10;

      // Read and write together on a hit behave as a store.
      access(32'h84, 32'hCAFEF00D, 1'b1, 1'b1, st, rd, sw, stg);
      chk("rw_both_stall", st, 0);
      chk("rw_both_we", sw, 1'b1);
      chk("rw_both_tag_vd", stg[24:23], 2'b11);
      access(32'h84, 32'h0, 1'b1, 1'b0, st, rd, sw, stg);
      chk("rw_both_readback", rd, 32'hCAFEF00D);
      drain();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
